// File: rtl/uart_ack_sender_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : uart_ack_pkg                                           |
// | Shared state encoding, default ACK byte and statistics helpers   |
// | for the UART acknowledge sender.                                 |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package uart_ack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_TX_WAIT  = 3'd2,
    ST_ACK_WAIT = 3'd3,
    ST_FINISH   = 3'd4
  } state_t;

  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hAB;
  localparam int         STAT_W           = 16;

  // Saturating increment used by the optional statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_ack_sender_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface : uart_ack_sender_if                                   |
// | Client request/result handshake plus UART tx/rx side signals.    |
// | slave = the sender block, master = client and UART environment.  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
interface uart_ack_sender_if;
  logic       req_valid;
  logic [7:0] req_data;
  logic       req_ready;
  logic       done;
  logic       ok;
  logic [3:0] attempts;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport slave (
    input  req_valid, req_data, tx_busy, rx_data, rx_ready,
    output req_ready, done, ok, attempts, tx_data, tx_start
  );

  modport master (
    output req_valid, req_data, tx_busy, rx_data, rx_ready,
    input  req_ready, done, ok, attempts, tx_data, tx_start
  );
endinterface
`default_nettype wire

// File: rtl/uart_ack_sender_ack_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : ack_timer                                               |
// | Loadable down-counter; expire marks the enabled cycle whose      |
// | decrement brings the count to zero.                              |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module ack_timer #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  // Load wins over counting; the counter parks at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expire = enable && (count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/uart_ack_sender.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : uart_ack_sender                                         |
// | Sends one byte through a UART transmitter and waits for an ACK   |
// | byte, resending on timeout up to MAX_RETRIES times.              |
// | Optional macro UART_ACK_STATS_EN adds timeout / bad-byte         |
// | statistics outputs.                                              |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module uart_ack_sender
  import uart_ack_pkg::*;
#(
  parameter logic [7:0] ACK_BYTE       = DEFAULT_ACK_BYTE,
  parameter int         TIMEOUT_CYCLES = 500000,
  parameter int         MAX_RETRIES    = 3
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef UART_ACK_STATS_EN
  output logic [STAT_W-1:0] stat_timeouts,
  output logic [STAT_W-1:0] stat_bad_bytes,
`endif
  uart_ack_sender_if.slave  bus
);

  localparam int                 TIMER_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD   = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [4:0]         LAST_ATTEMPT = 5'(MAX_RETRIES + 1);

  state_t     state, state_next;
  logic [7:0] tx_data_q;
  logic [4:0] attempt_cnt;
  logic [3:0] attempts_q;
  logic       ok_q;
  logic       busy_seen;
  logic       listening, rx_ack;
  logic       accept, retry, finish_ok, finish_fail;
  logic       timer_load, timer_en, timer_expire;
  logic       tx_start_c, req_ready_c, done_c;

  // Received bytes only matter while a frame is in flight or awaiting its ACK.
  assign listening = (state == ST_TX_WAIT) || (state == ST_ACK_WAIT);
  assign rx_ack    = listening && bus.rx_ready && (bus.rx_data == ACK_BYTE);

  ack_timer #(.WIDTH(TIMER_W)) u_ack_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (TIMER_LOAD),
    .enable     (timer_en),
    .expire     (timer_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state decode and single-cycle strobes; ACK is tested before expiry.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    retry       = 1'b0;
    finish_ok   = 1'b0;
    finish_fail = 1'b0;
    timer_load  = 1'b0;
    timer_en    = 1'b0;
    tx_start_c  = 1'b0;
    req_ready_c = 1'b0;
    done_c      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!bus.tx_busy) begin
          tx_start_c = 1'b1;
          state_next = ST_TX_WAIT;
        end
      end
      ST_TX_WAIT: begin
        if (rx_ack) begin
          finish_ok  = 1'b1;
          state_next = ST_FINISH;
        end else if (busy_seen && !bus.tx_busy) begin
          timer_load = 1'b1;
          state_next = ST_ACK_WAIT;
        end
      end
      ST_ACK_WAIT: begin
        timer_en = 1'b1;
        if (rx_ack) begin
          finish_ok  = 1'b1;
          state_next = ST_FINISH;
        end else if (timer_expire) begin
          if (attempt_cnt < LAST_ATTEMPT) begin
            retry      = 1'b1;
            state_next = ST_SEND;
          end else begin
            finish_fail = 1'b1;
            state_next  = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        done_c     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Transaction data: latched byte, attempt tracking and the held result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_data_q   <= 8'h00;
      attempt_cnt <= 5'd0;
      attempts_q  <= 4'd0;
      ok_q        <= 1'b0;
      busy_seen   <= 1'b0;
    end else begin
      if (accept) begin
        tx_data_q   <= bus.req_data;
        attempt_cnt <= 5'd1;
      end
      if (retry) attempt_cnt <= attempt_cnt + 5'd1;
      if (tx_start_c)                              busy_seen <= 1'b0;
      else if ((state == ST_TX_WAIT) && bus.tx_busy) busy_seen <= 1'b1;
      if (finish_ok || finish_fail) begin
        ok_q       <= finish_ok;
        attempts_q <= (attempt_cnt > 5'd15) ? 4'hF : attempt_cnt[3:0];
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.tx_start  = tx_start_c;
  assign bus.done      = done_c;
  assign bus.ok        = ok_q;
  assign bus.attempts  = attempts_q;
  assign bus.tx_data   = tx_data_q;

`ifdef UART_ACK_STATS_EN
  logic              rx_bad;
  logic [STAT_W-1:0] timeouts_q, bad_bytes_q;

  assign rx_bad = listening && bus.rx_ready && (bus.rx_data != ACK_BYTE);

  // Saturating counts of acted-upon timeouts and rejected bytes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timeouts_q  <= '0;
      bad_bytes_q <= '0;
    end else begin
      if (retry || finish_fail) timeouts_q  <= sat_inc(timeouts_q);
      if (rx_bad)               bad_bytes_q <= sat_inc(bad_bytes_q);
    end
  end

  assign stat_timeouts  = timeouts_q;
  assign stat_bad_bytes = bad_bytes_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_ack_sender.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_uart_ack_sender                                      |
// | Directed self-checking bench for uart_ack_sender with a simple   |
// | UART transmitter model (busy for FRAME cycles after tx_start).   |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_uart_ack_sender;

  localparam int TIMEOUT     = 1000;
  localparam int MAX_RETRIES = 3;
  localparam int FRAME       = 20;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic model_busy = 1'b0;
  logic hold_busy  = 1'b0;

  always #5 clk = ~clk;

  uart_ack_sender_if bus ();
  assign bus.tx_busy = model_busy | hold_busy;

`ifdef UART_ACK_STATS_EN
  logic [15:0] stat_timeouts;
  logic [15:0] stat_bad_bytes;
`endif

  uart_ack_sender #(
    .ACK_BYTE       (8'hAB),
    .TIMEOUT_CYCLES (TIMEOUT),
    .MAX_RETRIES    (MAX_RETRIES)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
`ifdef UART_ACK_STATS_EN
    .stat_timeouts  (stat_timeouts),
    .stat_bad_bytes (stat_bad_bytes),
`endif
    .bus            (bus)
  );

  int cyc = 0;
  int start_cnt = 0, last_start_cyc = -1;
  int done_cnt = 0, done_cyc = -1;
  int accept_cnt = 0;
  int fall_cnt = 0, fall_edge = -1;
  int gap_log [32];
  int n_cmp = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.tx_start) begin
      if (start_cnt < 32) gap_log[start_cnt] = cyc - fall_edge;
      start_cnt      = start_cnt + 1;
      last_start_cyc = cyc;
    end
    if (bus.done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (bus.req_valid && bus.req_ready) accept_cnt = accept_cnt + 1;
  end

  // UART transmitter model; fall_edge is the first clock edge that sees busy low.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_start) begin
        @(posedge clk); #1;
        model_busy = 1'b1;
        repeat (FRAME) @(posedge clk);
        #1;
        model_busy = 1'b0;
        fall_edge  = cyc + 1;
        fall_cnt   = fall_cnt + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_fall(input int target, input string tag);
    int n = 0;
    while ((fall_cnt < target) && (n < 3000)) begin tick(); n++; end
    check_eq(tag, 32'(fall_cnt >= target), 32'd1);
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while ((done_cnt < target) && (n < budget)) begin tick(); n++; end
    check_eq(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic pulse_rx(input logic [7:0] data);
    bus.rx_data  = data;
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  // Presents one request for one cycle; returns the accepting edge.
  task automatic send_req(input logic [7:0] data, output int acc_edge);
    int n = 0;
    while (!bus.req_ready && (n < 100)) begin tick(); n++; end
    bus.req_valid = 1'b1;
    bus.req_data  = data;
    acc_edge      = cyc + 1;
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, f0, a0, acc, x;
    bus.req_valid = 1'b0;
    bus.req_data  = 8'h00;
    bus.rx_ready  = 1'b0;
    bus.rx_data   = 8'h00;

    // Reset state
    reset_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst_tx_start",  32'(bus.tx_start),  32'd0);
    check_eq("rst_done",      32'(bus.done),      32'd0);
    check_eq("rst_ok",        32'(bus.ok),        32'd0);
    check_eq("rst_attempts",  32'(bus.attempts),  32'd0);
    check_eq("rst_tx_data",   32'(bus.tx_data),   32'h00);
    reset_n = 1'b1;
    tick();

    // 0x5A acknowledged 200 cycles into the wait
    s0 = start_cnt; d0 = done_cnt; f0 = fall_cnt;
    send_req(8'h5A, acc);
    tick();
    check_eq("t1_start_latency", 32'(last_start_cyc), 32'(acc));
    check_eq("t1_tx_data", 32'(bus.tx_data), 32'h5A);
    wait_fall(f0 + 1, "t1_fall_seen");
    wait_cyc(fall_edge + 200);
    pulse_rx(8'hAB);
    wait_done(d0 + 1, 2000, "t1_done_seen");
    check_eq("t1_ok",       32'(bus.ok),       32'd1);
    check_eq("t1_attempts", 32'(bus.attempts), 32'd1);
    check_eq("t1_starts",   32'(start_cnt - s0), 32'd1);
    check_eq("t1_tx_held",  32'(bus.tx_data),  32'h5A);

    // 0x11 never answered: four attempts then failure
    s0 = start_cnt; d0 = done_cnt;
    send_req(8'h11, acc);
    wait_done(d0 + 1, 6000, "t2_done_seen");
    check_eq("t2_ok",       32'(bus.ok),       32'd0);
    check_eq("t2_attempts", 32'(bus.attempts), 32'd4);
    check_eq("t2_starts",   32'(start_cnt - s0), 32'd4);
    for (int i = 1; i < 4; i++) check_eq("t2_retry_gap", 32'(gap_log[s0 + i]), 32'(TIMEOUT));
    check_eq("t2_final_timeout", 32'(done_cyc - fall_edge), 32'(TIMEOUT));
`ifdef UART_ACK_STATS_EN
    check_eq("t2_stat_timeouts", 32'(stat_timeouts), 32'd4);
`endif

    // 0x22: a wrong byte is ignored, then ACK
    s0 = start_cnt; d0 = done_cnt; f0 = fall_cnt;
    send_req(8'h22, acc);
    wait_fall(f0 + 1, "t3_fall_seen");
    wait_cyc(fall_edge + 10);
    pulse_rx(8'h00);
    wait_cyc(fall_edge + 20);
    check_eq("t3_no_done_on_bad", 32'(done_cnt - d0), 32'd0);
    pulse_rx(8'hAB);
    wait_done(d0 + 1, 2000, "t3_done_seen");
    check_eq("t3_ok",       32'(bus.ok),       32'd1);
    check_eq("t3_attempts", 32'(bus.attempts), 32'd1);
    check_eq("t3_starts",   32'(start_cnt - s0), 32'd1);
`ifdef UART_ACK_STATS_EN
    check_eq("t3_stat_bad_bytes", 32'(stat_bad_bytes), 32'd1);
`endif

    // 0x33: ACK on the exact expiry cycle of attempt 2
    s0 = start_cnt; d0 = done_cnt; f0 = fall_cnt;
    send_req(8'h33, acc);
    wait_fall(f0 + 2, "t4_second_fall_seen");
    wait_cyc(fall_edge + TIMEOUT - 1);
    pulse_rx(8'hAB);
    wait_done(d0 + 1, 100, "t4_done_seen");
    check_eq("t4_ok",        32'(bus.ok),       32'd1);
    check_eq("t4_attempts",  32'(bus.attempts), 32'd2);
    check_eq("t4_done_cycle", 32'(done_cyc - fall_edge), 32'(TIMEOUT));
    repeat (1200) tick();
    check_eq("t4_no_third_start", 32'(start_cnt - s0), 32'd2);

    // 0x44: transmitter busy at request, req_valid held throughout
    s0 = start_cnt; d0 = done_cnt; f0 = fall_cnt; a0 = accept_cnt;
    hold_busy     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_data  = 8'h44;
    tick();
    repeat (50) tick();
    check_eq("t5_no_start_while_busy", 32'(start_cnt - s0), 32'd0);
    hold_busy = 1'b0;
    x = cyc;
    tick();
    check_eq("t5_start_on_idle", 32'(last_start_cyc), 32'(x));
    check_eq("t5_tx_data", 32'(bus.tx_data), 32'h44);
    wait_fall(f0 + 1, "t5_fall_seen");
    pulse_rx(8'hAB);
    wait_done(d0 + 1, 2000, "t5_done_seen");
    bus.req_valid = 1'b0;
    check_eq("t5_single_accept", 32'(accept_cnt - a0), 32'd1);
    check_eq("t5_ok",       32'(bus.ok),       32'd1);
    check_eq("t5_attempts", 32'(bus.attempts), 32'd1);

    // 0x66: reset during ACK_WAIT
    f0 = fall_cnt;
    send_req(8'h66, acc);
    wait_fall(f0 + 1, "t6_fall_seen");
    wait_cyc(fall_edge + 100);
    reset_n = 1'b0;
    tick();
    check_eq("t6_tx_start", 32'(bus.tx_start), 32'd0);
    check_eq("t6_done",     32'(bus.done),     32'd0);
    check_eq("t6_ok",       32'(bus.ok),       32'd0);
    check_eq("t6_attempts", 32'(bus.attempts), 32'd0);
    check_eq("t6_tx_data",  32'(bus.tx_data),  32'h00);
`ifdef UART_ACK_STATS_EN
    check_eq("t6_stat_timeouts",  32'(stat_timeouts),  32'd0);
    check_eq("t6_stat_bad_bytes", 32'(stat_bad_bytes), 32'd0);
`endif
    reset_n = 1'b1;
    tick();
    check_eq("t6_req_ready", 32'(bus.req_ready), 32'd1);
    s0 = start_cnt; d0 = done_cnt;
    repeat (1200) tick();
    check_eq("t6_no_done",  32'(done_cnt - d0),  32'd0);
    check_eq("t6_no_start", 32'(start_cnt - s0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
